// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed 32-bit registers with independent
// write (AW/W in any order) and read channels, all outputs registered.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    wstate_e                              wstate_q, wstate_d;
    rstate_e                              rstate_q, rstate_d;
    logic                                 awready_q, awready_d, wready_q, wready_d;
    logic                                 bvalid_q, bvalid_d, arready_q, arready_d;
    logic                                 rvalid_q, rvalid_d;
    logic [1:0]                           bresp_q, bresp_d, rresp_q, rresp_d;
    logic [IDX_W-1:0]                     aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NB-1:0]                        wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      c_idx, ar_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [NB-1:0]         c_strb;
    logic                  unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs  = S_AXI_AWVALID & awready_q;
    assign w_hs   = S_AXI_WVALID & wready_q;
    assign ar_hs  = S_AXI_ARVALID & arready_q;
    assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

    // Write channel: whichever of AW/W arrives first is parked until its partner shows up.
    always_comb begin
        wstate_d = wstate_q;
        aw_idx_d = aw_idx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        regs_d   = regs_q;
        commit   = 1'b0;
        c_idx    = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        c_data   = S_AXI_WDATA;
        c_strb   = S_AXI_WSTRB;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end else if (aw_hs) begin
                    aw_idx_d = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    wstate_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs) begin
                commit   = 1'b1;
                c_idx    = aw_idx_q;
                wstate_d = W_RESP;
            end
            W_HAVE_W: if (aw_hs) begin
                commit   = 1'b1;
                c_data   = wdata_q;
                c_strb   = wstrb_q;
                wstate_d = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        if (commit) begin
            bresp_d = (int'(c_idx) < NUM_REGS) ? 2'b00 : 2'b10;
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < NB; b++)
                    if (int'(c_idx) == i && c_strb[b]) regs_d[i][8*b +: 8] = c_data[8*b +: 8];
        end
        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
        bvalid_d  = (wstate_d == W_RESP);
    end

    // Read channel samples regs_q, so a same-cycle write to the same register reads the old value.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_DATA;
                rdata_d  = '0;
                for (int i = 0; i < NUM_REGS; i++)
                    if (int'(ar_idx) == i) rdata_d = regs_q[i];
                rresp_d = (int'(ar_idx) < NUM_REGS) ? 2'b00 : 2'b10;
            end
            R_DATA: if (S_AXI_RREADY) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            regs_q    <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_out       = regs_q;
endmodule
